// File: rtl/matmul_io_pkg.sv
// Shared definitions for the matmul core's result byte stream: accumulator
// geometry, reader state encoding and the accumulator sign-extension helper.
package matmul_io_pkg;

  localparam int ACC_W_DFLT            = 17;
  localparam int ACC_BYTES_DFLT        = 3;
  localparam int RESULTS_PER_TILE_DFLT = 4;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Sign-extend the low acc_w bits of word to 64 bits; bits at and above
  // acc_w are ignored. Callers narrow the result to their output width.
  function automatic logic [63:0] sign_extend_acc(input logic [63:0] word,
                                                   input int acc_w);
    logic [63:0] ext;
    ext = 64'd0;
    for (int i = 0; i < 64; i++) begin
      if (i < acc_w) begin
        ext[i] = word[i];
      end else begin
        ext[i] = word[acc_w-1];
      end
    end
    return ext;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with head-of-queue output and full/empty flags.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_valid,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign empty      = (count_r == (AW+1)'(0));
  assign full       = (count_r == (AW+1)'(DEPTH));
  assign pop_ok_s   = pop & ~empty;
  assign push_ok_s  = push & (~full | pop_ok_s);
  assign head_valid = ~empty;
  assign head_data  = empty ? {W{1'b0}} : mem_r[rd_ptr_r];

  // Storage array write; contents are don't-care until counted valid.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/matmul_result_unpacker.sv
// Reassembles little-endian accumulator bytes from the matmul core into
// sign-extended results, tags the last result of each tile and buffers them
// behind a valid/ready interface. OUT_W up to 64 is supported.
module matmul_result_unpacker
  import matmul_io_pkg::*;
#(
  parameter int ACC_W            = ACC_W_DFLT,
  parameter int ACC_BYTES        = ACC_BYTES_DFLT,
  parameter int RESULTS_PER_TILE = RESULTS_PER_TILE_DFLT,
  parameter int OUT_W            = 32,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  input  logic             in_start,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             frame_err,
  output logic             busy
);

  localparam int BCW = (ACC_BYTES > 1) ? $clog2(ACC_BYTES) : 1;
  localparam int RCW = (RESULTS_PER_TILE > 1) ? $clog2(RESULTS_PER_TILE) : 1;
  localparam int WW  = 8 * ACC_BYTES;

  state_t           state_r;
  logic [BCW-1:0]   byte_cnt_r;
  logic [RCW-1:0]   res_cnt_r;
  logic [WW-1:0]    shift_r;
  logic             overflow_r;
  logic             frame_err_r;

  logic             start_s;
  logic             accept_s;
  logic             complete_s;
  logic             last_s;
  logic [BCW-1:0]   pos_s;
  logic [RCW-1:0]   res_idx_s;
  logic [WW-1:0]    word_s;
  logic [OUT_W-1:0] push_data_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;

  // Decide where this byte lands and whether it finishes a result; a start
  // byte always restarts at byte 0 of result 0 with a cleared word.
  always_comb begin
    start_s  = in_valid & in_start;
    accept_s = start_s | (in_valid & (state_r == COLLECT));
    if (start_s) begin
      pos_s     = '0;
      res_idx_s = '0;
      word_s    = '0;
    end else begin
      pos_s     = byte_cnt_r;
      res_idx_s = res_cnt_r;
      word_s    = shift_r;
    end
    word_s[int'(pos_s)*8 +: 8] = in_byte;
    complete_s  = accept_s & (pos_s == BCW'(ACC_BYTES-1));
    last_s      = (res_idx_s == RCW'(RESULTS_PER_TILE-1));
    push_data_s = OUT_W'(sign_extend_acc(64'(word_s), ACC_W));
  end

  // Collection state machine, byte/result counters and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      byte_cnt_r  <= '0;
      res_cnt_r   <= '0;
      shift_r     <= '0;
      overflow_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (start_s && (state_r == COLLECT)) begin
        frame_err_r <= 1'b1;
      end
      if (complete_s && fifo_full_s && !out_ready) begin
        overflow_r <= 1'b1;
      end
      if (accept_s) begin
        if (complete_s) begin
          byte_cnt_r <= '0;
          shift_r    <= '0;
          if (last_s) begin
            state_r   <= IDLE;
            res_cnt_r <= '0;
          end else begin
            state_r   <= COLLECT;
            res_cnt_r <= res_idx_s + RCW'(1);
          end
        end else begin
          state_r    <= COLLECT;
          byte_cnt_r <= pos_s + BCW'(1);
          res_cnt_r  <= res_idx_s;
          shift_r    <= word_s;
        end
      end
    end
  end

  sync_fifo #(
    .W     (OUT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (complete_s),
    .push_data  ({last_s, push_data_s}),
    .pop        (out_ready),
    .head_data  ({out_last, out_data}),
    .head_valid (out_valid),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s)
  );

  assign overflow  = overflow_r;
  assign frame_err = frame_err_r;
  assign busy      = (state_r == COLLECT) && !fifo_empty_s ? 1'b1 : (state_r == COLLECT);

endmodule

// File: tb/tb_matmul_result_unpacker.sv
// Bench for matmul_result_unpacker: byte-level driver, queue scoreboard
// checked on every accepted output, a vector table and directed sequences.
module tb_matmul_result_unpacker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_start = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        overflow;
  logic        frame_err;
  logic        busy;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [31:0] exp;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[8];
  int   total = 0;
  int   bad = 0;
  int   pop_cnt = 0;

  matmul_result_unpacker dut (
    .clk       (clk),
    .reset     (reset),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_start  (in_start),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard: each handshake seen mid-cycle completes at the next edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got data %h last %b want nothing", out_data, out_last);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data", 64'(out_data), 64'(e.data));
        check("out_last", 64'(out_last), 64'(e.last));
      end
      pop_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic s);
    in_byte  = b;
    in_start = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_start = 1'b0;
  endtask

  task automatic send_result(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic s, input logic [31:0] exp_data, input logic exp_last,
                             input logic do_push);
    if (do_push) exp_q.push_back({exp_last, exp_data});
    send_byte(b0, s);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int p0;
    vecs[0] = '{8'h10, 8'h00, 8'h00, 32'h0000_0010};
    vecs[1] = '{8'hFF, 8'hFF, 8'h01, 32'hFFFF_FFFF};
    vecs[2] = '{8'h00, 8'h00, 8'h01, 32'hFFFF_0000};
    vecs[3] = '{8'hFF, 8'hFF, 8'hFE, 32'h0000_FFFF};
    vecs[4] = '{8'h34, 8'h12, 8'h00, 32'h0000_1234};
    vecs[5] = '{8'h00, 8'h00, 8'h00, 32'h0000_0000};
    vecs[6] = '{8'h01, 8'h00, 8'hFF, 32'hFFFF_0001};
    vecs[7] = '{8'hFE, 8'hFF, 8'h00, 32'h0000_FFFE};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;

    // Positive tile with first-result latency and busy tracking.
    out_ready = 1'b1;
    exp_q.push_back({1'b0, 32'h0000_0010});
    send_byte(8'h10, 1'b1);
    check("busy_after_start", 64'(busy), 64'd1);
    send_byte(8'h00, 1'b0);
    check("valid_before_final", 64'(out_valid), 64'd0);
    send_byte(8'h00, 1'b0);
    check("valid_after_final", 64'(out_valid), 64'd1);
    for (int i = 1; i < 4; i++) begin
      send_result(8'h10, 8'h00, 8'h00, 1'b0, 32'h0000_0010, (i == 3), 1'b1);
    end
    check("busy_after_tile", 64'(busy), 64'd0);
    wait_drain("drain_positive");

    // Vector table: two tiles of sign-extension cases.
    for (int i = 0; i < 8; i++) begin
      send_result(vecs[i].b0, vecs[i].b1, vecs[i].b2, (i % 4 == 0), vecs[i].exp, (i % 4 == 3), 1'b1);
    end
    wait_drain("drain_table");

    // Backpressure and overflow: only the first tile fits.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_result(8'(i + 1), 8'h00, 8'h00, (i % 4 == 0), 32'(i + 1), (i == 3), (i < 4));
      if (i == 3) check("overflow_at_full", 64'(overflow), 64'd0);
      if (i == 4) check("overflow_after_drop", 64'(overflow), 64'd1);
    end
    check("head_hold_data", 64'(out_data), 64'h1);
    check("head_hold_last", 64'(out_last), 64'd0);
    check("frame_err_clean", 64'(frame_err), 64'd0);
    p0 = pop_cnt;
    out_ready = 1'b1;
    wait_drain("drain_overflow");
    repeat (5) @(posedge clk);
    #1;
    check("overflow_pop_count", 64'(pop_cnt - p0), 64'd4);
    check("overflow_sticky", 64'(overflow), 64'd1);

    // Full FIFO with a pop in the same cycle as the next push.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_result(8'(8'h20 + i), 8'h00, 8'h00, (i == 0), 32'(32'h20 + i), (i == 3), 1'b1);
    end
    exp_q.push_back({1'b0, 32'h0000_0030});
    send_byte(8'h30, 1'b1);
    send_byte(8'h00, 1'b0);
    out_ready = 1'b1;
    send_byte(8'h00, 1'b0);
    for (int i = 1; i < 4; i++) begin
      send_result(8'(8'h30 + i), 8'h00, 8'h00, 1'b0, 32'(32'h30 + i), (i == 3), 1'b1);
    end
    wait_drain("drain_full_pop");
    check("full_pop_no_overflow", 64'(overflow), 64'd0);

    // Resync: start mid-result discards the partial 0xAA word.
    do_reset();
    out_ready = 1'b1;
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b0);
    check("frame_err_before", 64'(frame_err), 64'd0);
    send_result(8'h05, 8'h00, 8'h00, 1'b1, 32'h0000_0005, 1'b0, 1'b1);
    check("frame_err_set", 64'(frame_err), 64'd1);
    for (int i = 1; i < 4; i++) begin
      send_result(8'(i + 5), 8'h00, 8'h00, 1'b0, 32'(i + 5), (i == 3), 1'b1);
    end
    wait_drain("drain_resync");

    // Reset mid-tile, then non-start bytes are ignored.
    do_reset();
    out_ready = 1'b0;
    send_result(8'h44, 8'h00, 8'h00, 1'b1, 32'h0000_0044, 1'b0, 1'b1);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_overflow", 64'(overflow), 64'd0);
    check("midrst_frame_err", 64'(frame_err), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send_byte(8'(8'h70 + i), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("ignored_out_valid", 64'(out_valid), 64'd0);
    check("ignored_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 4; i++) begin
      send_result(8'h00, 8'h80, 8'h00, (i == 0), 32'h0000_8000, (i == 3), 1'b1);
    end
    wait_drain("drain_recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
